// File: rtl/systolic_ws_db.sv
// systolic_ws_db: weight-stationary ROWS x COLS signed MAC array with two weight banks.
// Weights for the next tile shift into one bank while activations tagged with the
// other bank compute, so a bank switch costs no drain bubble.
// Optional build macro SYSTOLIC_DESKEW_EN: per-column output deskew so every column
// of a vector emerges in the same cycle (latency ROWS+COLS-1).
module systolic_ws_db #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int A_W  = 8,
   parameter int W_W  = 8,
   parameter int P_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ROWS-1:0]       a_valid,
   input  logic [ROWS*A_W-1:0]   a_data,
   input  logic [ROWS-1:0]       a_bank,
   input  logic [COLS*P_W-1:0]   bias,
   input  logic                  w_load,
   input  logic                  w_bank,
   input  logic [COLS*W_W-1:0]   w_data,
   output logic                  w_done,
   output logic [1:0]            bank_busy,
   output logic                  err_conflict,
   output logic [COLS-1:0]       of_valid,
   output logic [COLS*P_W-1:0]   of_data
);
   localparam int CW = $clog2(ROWS + 1);

   function automatic logic [P_W-1:0] sext_a(input logic [A_W-1:0] v);
      return {{(P_W-A_W){v[A_W-1]}}, v};
   endfunction

   function automatic logic [P_W-1:0] sext_w(input logic [W_W-1:0] v);
      return {{(P_W-W_W){v[W_W-1]}}, v};
   endfunction

   logic [W_W-1:0] r_wt [2][ROWS][COLS];
   logic [A_W-1:0] r_a  [ROWS][COLS];
   logic           r_av [ROWS][COLS];
   logic           r_ab [ROWS][COLS];
   logic [P_W-1:0] r_p  [ROWS][COLS];
   logic [CW-1:0]  r_cnt;
   logic           r_last_bank;
   logic           r_done;
   logic           r_err;

   logic [A_W-1:0] w_in_a [ROWS][COLS];
   logic           w_in_v [ROWS][COLS];
   logic           w_in_b [ROWS][COLS];
   logic [P_W-1:0] w_pin  [ROWS][COLS];
   logic [P_W-1:0] w_mac  [ROWS][COLS];
   logic [P_W-1:0] w_bias_skew [COLS];
   logic [1:0]     w_busy;

   // Bias for column j is delayed j cycles so it meets the skewed activation wavefront.
   for (genvar j = 0; j < COLS; j++) begin : g_bias
      if (j == 0) begin : g_direct
         assign w_bias_skew[j] = bias[P_W-1:0];
      end else begin : g_chain
         logic [P_W-1:0] r_sk [j];
         // Shift the column bias down a j-deep delay line.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < j; k++) r_sk[k] <= '0;
            end else begin
               r_sk[0] <= bias[j*P_W +: P_W];
               for (int k = 1; k < j; k++) r_sk[k] <= r_sk[k-1];
            end
         end
         assign w_bias_skew[j] = r_sk[j-1];
      end
   end

   // PE inputs (left neighbour or array edge), partial-sum inputs and MAC results.
   always_comb begin
      for (int i = 0; i < ROWS; i++) begin
         w_in_a[i][0] = a_data[i*A_W +: A_W];
         w_in_v[i][0] = a_valid[i];
         w_in_b[i][0] = a_bank[i];
         for (int j = 1; j < COLS; j++) begin
            w_in_a[i][j] = r_a[i][j-1];
            w_in_v[i][j] = r_av[i][j-1];
            w_in_b[i][j] = r_ab[i][j-1];
         end
      end
      for (int j = 0; j < COLS; j++) begin
         w_pin[0][j] = w_bias_skew[j];
         for (int i = 1; i < ROWS; i++) w_pin[i][j] = r_p[i-1][j];
      end
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            w_mac[i][j] = w_pin[i][j] +
                          sext_a(w_in_a[i][j]) * sext_w(r_wt[w_in_b[i][j]][i][j]);
         end
      end
   end

   // A bank is busy while any valid activation tagged with it is at the row-0 input or inside a PE.
   always_comb begin
      w_busy    = 2'b00;
      w_busy[0] = a_valid[0] & ~a_bank[0];
      w_busy[1] = a_valid[0] &  a_bank[0];
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            w_busy[0] = w_busy[0] | (r_av[i][j] & ~r_ab[i][j]);
            w_busy[1] = w_busy[1] | (r_av[i][j] &  r_ab[i][j]);
         end
      end
   end

   // Activation/valid/tag pipelines move right; partial sums update only for valid slots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
               r_a[i][j]  <= '0;
               r_av[i][j] <= 1'b0;
               r_ab[i][j] <= 1'b0;
               r_p[i][j]  <= '0;
            end
         end
      end else begin
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
               r_a[i][j]  <= w_in_a[i][j];
               r_av[i][j] <= w_in_v[i][j];
               r_ab[i][j] <= w_in_b[i][j];
               if (w_in_v[i][j]) r_p[i][j] <= w_mac[i][j];
            end
         end
      end
   end

   // Weight words shift down the selected bank; the other bank is left alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < ROWS; i++)
               for (int j = 0; j < COLS; j++) r_wt[b][i][j] <= '0;
      end else if (w_load) begin
         for (int b = 0; b < 2; b++) begin
            if (w_bank == 1'(b)) begin
               for (int j = 0; j < COLS; j++) begin
                  r_wt[b][0][j] <= w_data[j*W_W +: W_W];
                  for (int i = 1; i < ROWS; i++) r_wt[b][i][j] <= r_wt[b][i-1][j];
               end
            end
         end
      end
   end

   // Load counter, done pulse and sticky load-while-busy error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_last_bank <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= r_err | (w_load & w_busy[w_bank]);
         if (w_load) begin
            r_last_bank <= w_bank;
            if ((w_bank != r_last_bank) && (r_cnt != '0)) begin
               r_cnt <= CW'(1);
            end else if (r_cnt == CW'(ROWS-1)) begin
               r_cnt  <= '0;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign w_done       = r_done;
   assign err_conflict = r_err;
   assign bank_busy    = w_busy;

   for (genvar j = 0; j < COLS; j++) begin : g_out
`ifdef SYSTOLIC_DESKEW_EN
      if (j < COLS-1) begin : g_dsk
         localparam int D = COLS-1-j;
         logic           r_dv [D];
         logic [P_W-1:0] r_dd [D];
         // Delay early columns so all columns of a vector leave together.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < D; k++) begin
                  r_dv[k] <= 1'b0;
                  r_dd[k] <= '0;
               end
            end else begin
               r_dv[0] <= r_av[ROWS-1][j];
               r_dd[0] <= r_p[ROWS-1][j];
               for (int k = 1; k < D; k++) begin
                  r_dv[k] <= r_dv[k-1];
                  r_dd[k] <= r_dd[k-1];
               end
            end
         end
         assign of_valid[j]           = r_dv[D-1];
         assign of_data[j*P_W +: P_W] = r_dd[D-1];
      end else begin : g_thru
         assign of_valid[j]           = r_av[ROWS-1][j];
         assign of_data[j*P_W +: P_W] = r_p[ROWS-1][j];
      end
`else
      assign of_valid[j]           = r_av[ROWS-1][j];
      assign of_data[j*P_W +: P_W] = r_p[ROWS-1][j];
`endif
   end

endmodule

// File: tb/tb_systolic_ws_db.sv
// Directed bench for systolic_ws_db (ROWS=COLS=4, 8-bit operands, 32-bit sums).
module tb_systolic_ws_db;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int A_W  = 8;
   localparam int W_W  = 8;
   localparam int P_W  = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [ROWS-1:0]     a_valid;
   logic [ROWS*A_W-1:0] a_data;
   logic [ROWS-1:0]     a_bank;
   logic [COLS*P_W-1:0] bias;
   logic                w_load;
   logic                w_bank;
   logic [COLS*W_W-1:0] w_data;
   logic                w_done;
   logic [1:0]          bank_busy;
   logic                err_conflict;
   logic [COLS-1:0]     of_valid;
   logic [COLS*P_W-1:0] of_data;

   systolic_ws_db #(.ROWS(ROWS), .COLS(COLS), .A_W(A_W), .W_W(W_W), .P_W(P_W)) dut (
      .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_bank(a_bank),
      .bias(bias), .w_load(w_load), .w_bank(w_bank), .w_data(w_data),
      .w_done(w_done), .bank_busy(bank_busy), .err_conflict(err_conflict),
      .of_valid(of_valid), .of_data(of_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Stimulus tables: vectors, their hand-computed results, and one load sequence.
   int              nv;
   logic [A_W-1:0]  va    [8][ROWS];
   logic            vb    [8];
   logic [P_W-1:0]  vbias [8][COLS];
   logic [P_W-1:0]  vexp  [8][COLS];
   int              ldn;
   int              ld_start;
   logic            ld_bank;
   logic [W_W-1:0]  ldw   [ROWS][COLS];
   int              err_from;
   logic            exp_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int lat(input int j);
`ifdef SYSTOLIC_DESKEW_EN
      return ROWS + COLS - 1;
`else
      return ROWS + j;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int v, input logic b,
                          input int a0, input int a1, input int a2, input int a3,
                          input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
      vb[v] = b;
      va[v][0] = 8'(a0); va[v][1] = 8'(a1); va[v][2] = 8'(a2); va[v][3] = 8'(a3);
      vbias[v][0] = p0; vbias[v][1] = p1; vbias[v][2] = p2; vbias[v][3] = p3;
      vexp[v][0] = e0; vexp[v][1] = e1; vexp[v][2] = e2; vexp[v][3] = e3;
   endtask

   // Load word k lands in row ROWS-1-k, so this builds val * identity.
   task automatic set_diag(input logic [7:0] val);
      for (int k = 0; k < ROWS; k++)
         for (int j = 0; j < COLS; j++)
            ldw[k][j] = (j == ROWS-1-k) ? val : 8'h00;
   endtask

   task automatic clear_inputs();
      a_valid = '0; a_data = '0; a_bank = '0; bias = '0;
      w_load = 1'b0; w_bank = 1'b0; w_data = '0;
   endtask

   // Drive skewed vectors and the load sequence for ncyc cycles, checking every cycle.
   task automatic run(input int ncyc);
      logic [COLS-1:0] ev;
      logic [1:0]      eb;
      logic            ed;
      int              u;
      for (int t = 0; t < ncyc; t++) begin
         for (int i = 0; i < ROWS; i++) begin
            u = t - i;
            if (u >= 0 && u < nv) begin
               a_valid[i] = 1'b1; a_data[i*A_W +: A_W] = va[u][i]; a_bank[i] = vb[u];
            end else begin
               a_valid[i] = 1'b0; a_data[i*A_W +: A_W] = '0; a_bank[i] = 1'b0;
            end
         end
         for (int j = 0; j < COLS; j++)
            bias[j*P_W +: P_W] = (t < nv) ? vbias[t][j] : 32'd0;
         w_bank = ld_bank;
         if (t >= ld_start && t < ld_start + ldn) begin
            w_load = 1'b1;
            for (int j = 0; j < COLS; j++) w_data[j*W_W +: W_W] = ldw[t-ld_start][j];
         end else begin
            w_load = 1'b0;
            w_data = '0;
         end
         #1;
         eb = 2'b00;
         if (t < nv) eb[vb[t]] = 1'b1;
         for (int v = 0; v < nv; v++)
            for (int i = 0; i < ROWS; i++)
               for (int j = 0; j < COLS; j++)
                  if (v + i + j + 1 == t) eb[vb[v]] = 1'b1;
         ev = '0;
         for (int j = 0; j < COLS; j++) begin
            u = t - lat(j);
            if (u >= 0 && u < nv) begin
               ev[j] = 1'b1;
               check($sformatf("data[%0d] t=%0d", j, t), of_data[j*P_W +: P_W], vexp[u][j]);
            end
         end
         ed = (ldn == ROWS) && (t == ld_start + ROWS);
         if (err_from >= 0 && t >= err_from) exp_err = 1'b1;
         check($sformatf("of_valid t=%0d", t), 32'(of_valid), 32'(ev));
         check($sformatf("bank_busy t=%0d", t), 32'(bank_busy), 32'(eb));
         check($sformatf("w_done t=%0d", t), 32'(w_done), 32'(ed));
         check($sformatf("err_conflict t=%0d", t), 32'(err_conflict), 32'(exp_err));
         step();
      end
      clear_inputs();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " of_valid"}, 32'(of_valid), 32'd0);
      check({tag, " bank_busy"}, 32'(bank_busy), 32'd0);
      check({tag, " w_done"}, 32'(w_done), 32'd0);
      check({tag, " err"}, 32'(err_conflict), 32'd0);
      for (int j = 0; j < COLS; j++)
         check($sformatf("%s of_data[%0d]", tag, j), of_data[j*P_W +: P_W], 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      nv = 0; ldn = 0; ld_start = 0; ld_bank = 1'b0; err_from = -1; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b0;

      // Identity into bank 0, then a=[1,2,3,4] with zero bias.
      set_diag(8'd1); ld_bank = 1'b0; ld_start = 0; ldn = 4; nv = 0; run(9);
      ldn = 0; nv = 1;
      set_vec(0, 1'b0, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4);
      run(10);

      // Ping-pong: four bank-0 vectors while bank 1 loads W1[i][j]=j+1, then two bank-1 vectors.
      for (int k = 0; k < ROWS; k++)
         for (int j = 0; j < COLS; j++) ldw[k][j] = 8'(j + 1);
      ld_bank = 1'b1; ld_start = 0; ldn = 4; nv = 6;
      set_vec(0, 1'b0, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4);
      set_vec(1, 1'b0, 5, 6, 7, 8, 32'd100, 32'd200, 32'd300, 32'd400,
              32'd105, 32'd206, 32'd307, 32'd408);
      set_vec(2, 1'b0, -1, -2, -3, -4, 32'd0, 32'd0, 32'd0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
      set_vec(3, 1'b0, 0, 0, 0, 0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
      set_vec(4, 1'b1, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd20, 32'd30, 32'd40);
      set_vec(5, 1'b1, 1, -1, 1, -1, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7);
      run(15);

      // Signed extremes: all weights -128, all activations -128.
      for (int k = 0; k < ROWS; k++)
         for (int j = 0; j < COLS; j++) ldw[k][j] = 8'h80;
      ld_bank = 1'b0; ld_start = 0; ldn = 4; nv = 0; run(9);
      ldn = 0; nv = 1;
      set_vec(0, 1'b0, -128, -128, -128, -128, 32'd0, 32'd0, 32'd0, 32'd0,
              32'd65536, 32'd65536, 32'd65536, 32'd65536);
      run(10);

      // Conflict: reload bank 0 with 2*I while a zero bank-0 vector is in flight.
      set_diag(8'd2); ld_bank = 1'b0; ld_start = 1; ldn = 4; nv = 1; err_from = 2;
      set_vec(0, 1'b0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      run(10);
      err_from = -1; ldn = 0; ld_start = 0;
      set_vec(0, 1'b0, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd4, 32'd6, 32'd8);
      run(10);

      // Wrap: identity in bank 1, bias 0x7FFFFFFF, product +1 only on column 0.
      set_diag(8'd1); ld_bank = 1'b1; ld_start = 0; ldn = 4; nv = 0; run(9);
      ldn = 0; nv = 1;
      set_vec(0, 1'b1, 1, 0, 0, 0,
              32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
              32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      run(10);

      // Reset with three vectors in flight.
      nv = 3;
      for (int v = 0; v < 3; v++)
         set_vec(v, 1'b1, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4);
      run(3);
      rst = 1'b1;
      #1;
      check_quiet("midreset");
      exp_err = 1'b0;
      step();
      rst = 1'b0;
      nv = 0; ldn = 0; run(9);
      nv = 1;
      set_vec(0, 1'b1, 1, 2, 3, 4, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5);
      run(10);
      set_diag(8'd1); ld_bank = 1'b0; ld_start = 0; ldn = 4; nv = 0; run(9);
      ldn = 0; nv = 1;
      set_vec(0, 1'b0, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4);
      run(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/systolic_ws_db.md
Name: systolic_ws_db

Overview:
- Parametrised weight-stationary systolic GEMM array with ROWS x COLS int MAC PEs and double-buffered (two-bank) weights.
- Weights for the next tile shift into the inactive bank while the active bank computes.
- Each activation carries a bank tag that travels rightward with the data, so a bank switch needs no drain bubble.
- Sits between the activation/weight feeders and the output accumulator/writeback in the GEMM datapath.

Parameters:
- ROWS, 4, PE rows; the reduction dimension per pass.
- COLS, 4, PE columns; output channels.
- A_W, 8, signed activation width.
- W_W, 8, signed weight width.
- P_W, 32, partial-sum and output width; must satisfy P_W >= A_W+W_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  ROWS  per-row activation valid
- a_data  in  ROWS*A_W  per-row activation
- a_bank  in  ROWS  per-row weight-bank tag
- bias  in  COLS*P_W  per-column bias, sampled with row-0 a_valid
- w_load  in  1  shift one weight word per column into the selected bank
- w_bank  in  1  bank being loaded
- w_data  in  COLS*W_W  per-column weight word
- w_done  out  1  one-cycle pulse when ROWS words have loaded into a bank
- bank_busy  out  2  bank b is referenced by an in-flight activation
- err_conflict  out  1  sticky load-while-busy error
- of_valid  out  COLS  per-column result valid
- of_data  out  COLS*P_W  per-column result

Behaviour:
- Reset (asynchronous): clears all PE registers, both weight banks, the valid/tag pipelines, the bias skew registers and the load counter. w_done, bank_busy, err_conflict, of_valid and of_data all read 0.
- Weight load: on each w_load cycle, PE(0,j).bank[w_bank] <= w_data[j] and PE(i,j).bank[w_bank] <= PE(i-1,j).bank[w_bank]. The other bank is untouched.
- After ROWS load cycles, the first word sits in row ROWS-1.
- The load counter counts 0..ROWS-1 and wraps. w_done pulses the cycle after the ROWS-th load.
- A change of w_bank mid-sequence resets the counter to 1, counting that load.
- Input skew is the caller's job: row i is presented i cycles after row 0 for the same output vector.
- Activation: PE(i,j) registers a_data/a_valid/a_bank rightward each cycle; invalid slots propagate as bubbles.
- MAC: when the PE's a_valid is set, p_out <= p_in + sext(a)*sext(bank[a_bank]); otherwise p_out holds.
- Row 0 p_in = bias[j], delayed j cycles by internal skew registers.
- Arithmetic wraps modulo 2^P_W.
- Result valid: PE(ROWS-1,j)'s registered valid drives of_valid[j].
- Latency from row-0 input to of_valid[j] is ROWS+j cycles; throughput is one vector per cycle.
- bank_busy[b] is the OR over all PE activation registers of (valid && tag==b), plus the row-0 input.
- Conflict: w_load && bank_busy[w_bank] still performs the load and sets err_conflict, which stays set until reset.
- Simultaneous load and compute on opposite banks is legal and bubble-free.
- Reset mid-operation discards all in-flight vectors and loaded weights; no outputs are produced for them.

Optional Feature:
- Macro: SYSTOLIC_DESKEW_EN.
- Defined: adds per-column deskew registers (COLS-1-j stages on column j), so all columns of one vector emerge together.
  - of_valid[*] are all equal.
  - Uniform latency is ROWS+COLS-1.
- Undefined: column-skewed outputs as described above; no deskew registers.

Test Plan:
- Identity weights, ROWS=COLS=4, bank 0 loaded with I, bias 0, a=[1,2,3,4] skewed -> of_data[j]=a[j] at cycles 4..7; w_done pulses after the 4th load.
- Signed extremes: a=-128 on all rows, weight=-128, bias=0 -> of_data=4*16384=65536 on every column.
- Ping-pong: compute with bank 0 while loading bank 1, then tag the next vector bank 1 -> back-to-back valids with no bubble; results match each bank's weights; err_conflict stays 0.
- Conflict: w_load to bank 0 while a bank-0 vector is in flight -> err_conflict=1 next cycle and held; the load still lands.
- Wrap: bias=0x7FFFFFFF, product +1 -> of_data=0x80000000.
- Reset asserted while 3 vectors are in flight -> all outputs 0 immediately; no of_valid afterwards; reloading and recompute give correct results.
- With SYSTOLIC_DESKEW_EN: all of_valid assert together at cycle ROWS+COLS-1 = 7.
